// File: rtl/branch_ctrl_if.sv
// ID-stage control/data bundle shared between the pipeline (master) and branch_ctrl (slave).
interface branch_ctrl_if;
  logic        stallD;
  logic        flushD;
  logic        branchD;
  logic        jumpD;
  logic        jrD;
  logic        linkD;
  logic        cmp_y;
  logic        opnd_ready;
  logic [31:0] pc_plus4D;
  logic [31:0] imm_extD;
  logic [31:0] rs_valD;
  logic [25:0] instr_indexD;

  logic        branch_stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        link_wr;
  logic [31:0] link_addr;
  logic        in_delayslotD;

  modport master (
    output stallD, flushD, branchD, jumpD, jrD, linkD, cmp_y, opnd_ready,
           pc_plus4D, imm_extD, rs_valD, instr_indexD,
    input  branch_stall, pc_src, pc_target, link_wr, link_addr, in_delayslotD
  );

  modport slave (
    input  stallD, flushD, branchD, jumpD, jrD, linkD, cmp_y, opnd_ready,
           pc_plus4D, imm_extD, rs_valD, instr_indexD,
    output branch_stall, pc_src, pc_target, link_wr, link_addr, in_delayslotD
  );
endinterface

// File: rtl/branch_ctrl.sv
// ID-stage branch/jump resolution: operand-wait stall, PC redirect, link write,
// delay-slot tracking and saturating conditional-branch statistics.
module branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] br_total_cnt,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic [1:0]       state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] SLOT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] taken_q, taken_d;

  logic ctl, need, active, wait_ops, resolve, taken;

  always_comb begin
    ctl      = bus.branchD | bus.jumpD;
    need     = bus.branchD | bus.jrD;
    // A live control instruction in IDLE/WAIT that is neither flushed nor reset.
    active   = !rst && (state_q != SLOT) && ctl && !bus.flushD;
    wait_ops = active && need && !bus.opnd_ready;
    resolve  = active && !bus.stallD && !wait_ops;
    taken    = bus.branchD ? bus.cmp_y : 1'b1;
  end

  always_comb begin
    bus.branch_stall  = wait_ops;
    bus.pc_src        = resolve && taken;
    bus.link_wr       = resolve && bus.linkD;
    bus.link_addr     = 32'd0;
    bus.pc_target     = 32'd0;
    bus.in_delayslotD = !rst && (state_q == SLOT);
    if (resolve) begin
      bus.link_addr = bus.pc_plus4D + 32'd4;
      if (bus.branchD)
        bus.pc_target = bus.pc_plus4D + (bus.imm_extD << 2);
      else if (bus.jrD)
        bus.pc_target = bus.rs_valD;
      else
        bus.pc_target = {bus.pc_plus4D[31:28], bus.instr_indexD, 2'b00};
    end
  end

  always_comb begin
    state_d = IDLE;
    if (bus.flushD) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, WAIT: begin
          if (resolve)       state_d = SLOT;
          else if (wait_ops) state_d = WAIT;
          else if (active)   state_d = state_q;  // operands ready but pipeline held
          else               state_d = IDLE;
        end
        SLOT:    state_d = bus.stallD ? SLOT : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    total_d = total_q;
    taken_d = taken_q;
    if (resolve && bus.branchD) begin
      if (total_q != CNT_MAX) total_d = total_q + 1'b1;
      if (bus.cmp_y && (taken_q != CNT_MAX)) taken_d = taken_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      total_q <= '0;
      taken_q <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      taken_q <= taken_d;
    end
  end

  assign br_total_cnt = total_q;
  assign br_taken_cnt = taken_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a default-width instance and a CNT_W=4 instance
// receive identical stimulus so counter saturation is observable.
module tb_branch_ctrl;

  logic clk;
  logic rst;

  branch_ctrl_if bus_a ();
  branch_ctrl_if bus_b ();

  logic [15:0] total_a, taken_a;
  logic [3:0]  total_b, taken_b;
  logic [1:0]  state_a, state_b;

  branch_ctrl #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .br_total_cnt(total_a), .br_taken_cnt(taken_a), .state_o(state_a)
  );

  branch_ctrl #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .br_total_cnt(total_b), .br_taken_cnt(taken_b), .state_o(state_b)
  );

  assign bus_b.stallD       = bus_a.stallD;
  assign bus_b.flushD       = bus_a.flushD;
  assign bus_b.branchD      = bus_a.branchD;
  assign bus_b.jumpD        = bus_a.jumpD;
  assign bus_b.jrD          = bus_a.jrD;
  assign bus_b.linkD        = bus_a.linkD;
  assign bus_b.cmp_y        = bus_a.cmp_y;
  assign bus_b.opnd_ready   = bus_a.opnd_ready;
  assign bus_b.pc_plus4D    = bus_a.pc_plus4D;
  assign bus_b.imm_extD     = bus_a.imm_extD;
  assign bus_b.rs_valD      = bus_a.rs_valD;
  assign bus_b.instr_indexD = bus_a.instr_indexD;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SLOT = 2'd2;

  int n_checks = 0;
  int n_errors = 0;
  int exp_total = 0;
  int exp_taken = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic br, input logic jp, input logic jr, input logic lk,
                       input logic cmp, input logic rdy, input logic stl, input logic fl);
    bus_a.branchD    = br;
    bus_a.jumpD      = jp;
    bus_a.jrD        = jr;
    bus_a.linkD      = lk;
    bus_a.cmp_y      = cmp;
    bus_a.opnd_ready = rdy;
    bus_a.stallD     = stl;
    bus_a.flushD     = fl;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 0, 1, 1, 1, 0, 0);
    bus_a.pc_plus4D = 32'h0000_1000;
    #1;
    n_checks++; if (bus_a.pc_src !== 1'b0) begin n_errors++; $display("FAIL rst_pc_src: got %0h expected 0", bus_a.pc_src); end
    n_checks++; if (bus_a.link_wr !== 1'b0) begin n_errors++; $display("FAIL rst_link_wr: got %0h expected 0", bus_a.link_wr); end
    n_checks++; if (bus_a.pc_target !== 32'h0) begin n_errors++; $display("FAIL rst_pc_target: got %h expected 0", bus_a.pc_target); end
    n_checks++; if (bus_a.link_addr !== 32'h0) begin n_errors++; $display("FAIL rst_link_addr: got %h expected 0", bus_a.link_addr); end
    n_checks++; if (bus_a.branch_stall !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %0h expected 0", bus_a.branch_stall); end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (state_a !== S_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d expected 0", state_a); end
    n_checks++; if (total_a !== 16'd0 || taken_a !== 16'd0) begin n_errors++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", total_a, taken_a); end
    n_checks++; if (bus_a.in_delayslotD !== 1'b0) begin n_errors++; $display("FAIL rst_slot: got %0h expected 0", bus_a.in_delayslotD); end
  endtask

  task automatic test_beq();
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 1, 0, 0);
    bus_a.pc_plus4D = 32'h0040_0004;
    bus_a.imm_extD  = 32'h0000_0003;
    #1;
    n_checks++; if (bus_a.pc_src !== 1'b1) begin n_errors++; $display("FAIL beq_pc_src: got %0h expected 1", bus_a.pc_src); end
    n_checks++; if (bus_a.pc_target !== 32'h0040_0010) begin n_errors++; $display("FAIL beq_target: got %h expected 00400010", bus_a.pc_target); end
    n_checks++; if (bus_a.link_wr !== 1'b0) begin n_errors++; $display("FAIL beq_link_wr: got %0h expected 0", bus_a.link_wr); end
    exp_total++; exp_taken++;
    // Delay slot holds another branch: it must be ignored.
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 1, 0, 0);
    #1;
    n_checks++; if (bus_a.in_delayslotD !== 1'b1) begin n_errors++; $display("FAIL beq_slot: got %0h expected 1", bus_a.in_delayslotD); end
    n_checks++; if (bus_a.pc_src !== 1'b0) begin n_errors++; $display("FAIL beq_slot_ignore: got %0h expected 0", bus_a.pc_src); end
    n_checks++; if (total_a !== 16'd1 || taken_a !== 16'd1) begin n_errors++; $display("FAIL beq_counts: got %0d/%0d expected 1/1", total_a, taken_a); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (state_a !== S_IDLE) begin n_errors++; $display("FAIL beq_back_idle: got %0d expected 0", state_a); end
    n_checks++; if (total_a !== 16'd1) begin n_errors++; $display("FAIL beq_slot_nocount: got %0d expected 1", total_a); end
  endtask

  task automatic test_wait();
    bus_a.pc_plus4D = 32'h0000_1000;
    bus_a.imm_extD  = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 1, 0, 0, 0);
      #1;
      n_checks++; if (bus_a.branch_stall !== 1'b1) begin n_errors++; $display("FAIL wait_stall%0d: got %0h expected 1", i, bus_a.branch_stall); end
      n_checks++; if (bus_a.pc_src !== 1'b0) begin n_errors++; $display("FAIL wait_pc_src%0d: got %0h expected 0", i, bus_a.pc_src); end
    end
    n_checks++; if (state_a !== S_WAIT) begin n_errors++; $display("FAIL wait_state: got %0d expected 1", state_a); end
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 1, 0, 0);
    #1;
    n_checks++; if (bus_a.branch_stall !== 1'b0) begin n_errors++; $display("FAIL wait_resolve_stall: got %0h expected 0", bus_a.branch_stall); end
    n_checks++; if (bus_a.pc_src !== 1'b1 || bus_a.pc_target !== 32'h0000_0FFC) begin n_errors++; $display("FAIL wait_resolve: got %0h/%h expected 1/00000ffc", bus_a.pc_src, bus_a.pc_target); end
    exp_total++; exp_taken++;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (state_a !== S_SLOT || bus_a.in_delayslotD !== 1'b1) begin n_errors++; $display("FAIL wait_slot: got %0d/%0h expected 2/1", state_a, bus_a.in_delayslotD); end
  endtask

  task automatic test_link_not_taken();
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 1, 0, 0);
    bus_a.pc_plus4D = 32'h0000_0100;
    bus_a.imm_extD  = 32'h0000_0010;
    #1;
    n_checks++; if (bus_a.pc_src !== 1'b0) begin n_errors++; $display("FAIL bltzal_pc_src: got %0h expected 0", bus_a.pc_src); end
    n_checks++; if (bus_a.link_wr !== 1'b1) begin n_errors++; $display("FAIL bltzal_link_wr: got %0h expected 1", bus_a.link_wr); end
    n_checks++; if (bus_a.link_addr !== 32'h0000_0104) begin n_errors++; $display("FAIL bltzal_link_addr: got %h expected 00000104", bus_a.link_addr); end
    exp_total++;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (total_a !== 16'(exp_total) || taken_a !== 16'(exp_taken)) begin n_errors++; $display("FAIL bltzal_counts: got %0d/%0d expected %0d/%0d", total_a, taken_a, exp_total, exp_taken); end
  endtask

  task automatic test_stall_jal();
    @(negedge clk);
    drive(0, 1, 0, 1, 0, 1, 1, 0);
    bus_a.pc_plus4D    = 32'h3000_0010;
    bus_a.instr_indexD = 26'h012_3456;
    #1;
    n_checks++; if (bus_a.pc_src !== 1'b0 || bus_a.link_wr !== 1'b0 || bus_a.branch_stall !== 1'b0) begin n_errors++; $display("FAIL jal_held: got %0h/%0h/%0h expected 0/0/0", bus_a.pc_src, bus_a.link_wr, bus_a.branch_stall); end
    @(negedge clk);
    drive(0, 1, 0, 1, 0, 1, 0, 0);
    #1;
    n_checks++; if (bus_a.pc_src !== 1'b1 || bus_a.pc_target !== 32'h3048_D158) begin n_errors++; $display("FAIL jal_target: got %0h/%h expected 1/3048d158", bus_a.pc_src, bus_a.pc_target); end
    n_checks++; if (bus_a.link_wr !== 1'b1 || bus_a.link_addr !== 32'h3000_0014) begin n_errors++; $display("FAIL jal_link: got %0h/%h expected 1/30000014", bus_a.link_wr, bus_a.link_addr); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    n_checks++; if (bus_a.in_delayslotD !== 1'b1) begin n_errors++; $display("FAIL jal_slot: got %0h expected 1", bus_a.in_delayslotD); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (state_a !== S_SLOT) begin n_errors++; $display("FAIL jal_slot_hold: got %0d expected 2", state_a); end
    @(negedge clk);
    #1;
    n_checks++; if (state_a !== S_IDLE) begin n_errors++; $display("FAIL jal_slot_exit: got %0d expected 0", state_a); end
  endtask

  task automatic test_jr();
    bus_a.rs_valD = 32'hBFC0_0380;
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (bus_a.branch_stall !== 1'b1) begin n_errors++; $display("FAIL jr_wait: got %0h expected 1", bus_a.branch_stall); end
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 1, 0, 0);
    #1;
    n_checks++; if (bus_a.pc_src !== 1'b1 || bus_a.pc_target !== 32'hBFC0_0380) begin n_errors++; $display("FAIL jr_target: got %0h/%h expected 1/bfc00380", bus_a.pc_src, bus_a.pc_target); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (total_a !== 16'(exp_total) || taken_a !== 16'(exp_taken)) begin n_errors++; $display("FAIL jr_counts: got %0d/%0d expected %0d/%0d", total_a, taken_a, exp_total, exp_taken); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 1, 1, 1);
    #1;
    n_checks++; if (state_a !== S_WAIT) begin n_errors++; $display("FAIL flush_pre_wait: got %0d expected 1", state_a); end
    n_checks++; if (bus_a.pc_src !== 1'b0 || bus_a.branch_stall !== 1'b0) begin n_errors++; $display("FAIL flush_suppress: got %0h/%0h expected 0/0", bus_a.pc_src, bus_a.branch_stall); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (state_a !== S_IDLE || bus_a.in_delayslotD !== 1'b0) begin n_errors++; $display("FAIL flush_idle: got %0d/%0h expected 0/0", state_a, bus_a.in_delayslotD); end
    n_checks++; if (total_a !== 16'(exp_total)) begin n_errors++; $display("FAIL flush_nocount: got %0d expected %0d", total_a, exp_total); end
  endtask

  task automatic test_rst_in_slot();
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    #1;
    n_checks++; if (state_a !== S_SLOT || bus_a.in_delayslotD !== 1'b0) begin n_errors++; $display("FAIL rst_slot_gate: got %0d/%0h expected 2/0", state_a, bus_a.in_delayslotD); end
    exp_total = 0; exp_taken = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (state_a !== S_IDLE || bus_a.in_delayslotD !== 1'b0) begin n_errors++; $display("FAIL rst_slot_exit: got %0d/%0h expected 0/0", state_a, bus_a.in_delayslotD); end
    n_checks++; if (total_a !== 16'd0 || taken_b !== 4'd0) begin n_errors++; $display("FAIL rst_slot_counts: got %0d/%0d expected 0/0", total_a, taken_b); end
  endtask

  task automatic test_precedence();
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 1, 0, 0);
    bus_a.pc_plus4D    = 32'h0000_2000;
    bus_a.imm_extD     = 32'h0000_0001;
    bus_a.instr_indexD = 26'h000_0040;
    #1;
    n_checks++; if (bus_a.pc_src !== 1'b0 || bus_a.pc_target !== 32'h0000_2004) begin n_errors++; $display("FAIL prec_branch: got %0h/%h expected 0/00002004", bus_a.pc_src, bus_a.pc_target); end
    exp_total++;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (total_a !== 16'(exp_total) || taken_a !== 16'(exp_taken)) begin n_errors++; $display("FAIL prec_counts: got %0d/%0d expected %0d/%0d", total_a, taken_a, exp_total, exp_taken); end
  endtask

  task automatic test_back_to_back_saturation();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 1, 1, 0, 0);
      exp_total++; exp_taken++;
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (i == 15) begin
        n_checks++; if (taken_b !== 4'hF) begin n_errors++; $display("FAIL sat_taken_reach: got %h expected f", taken_b); end
      end
    end
    @(negedge clk);
    #1;
    n_checks++; if (taken_b !== 4'hF || total_b !== 4'hF) begin n_errors++; $display("FAIL sat_hold: got %h/%h expected f/f", total_b, taken_b); end
    n_checks++; if (total_a !== 16'(exp_total) || taken_a !== 16'(exp_taken)) begin n_errors++; $display("FAIL sat_wide: got %0d/%0d expected %0d/%0d", total_a, taken_a, exp_total, exp_taken); end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus_a.pc_plus4D    = 32'h0;
    bus_a.imm_extD     = 32'h0;
    bus_a.rs_valD      = 32'h0;
    bus_a.instr_indexD = 26'h0;
    repeat (2) @(posedge clk);
    test_reset();
    test_beq();
    test_wait();
    test_link_not_taken();
    test_stall_jal();
    test_jr();
    test_flush();
    test_rst_in_slot();
    test_precedence();
    test_back_to_back_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
